// File: rtl/control_unit_pkg.sv
// control_unit_pkg: state and op-class enums, opcodes, datapath select/function
// codes and the idle control set shared by the sequencer and its decoder.
`default_nettype none

package control_unit_pkg;

   typedef enum logic [2:0] {
      S_INIT = 3'd0,
      S_F_LO = 3'd1,
      S_F_HI = 3'd2,
      S_EX1  = 3'd3,
      S_EX2  = 3'd4,
      S_EX3  = 3'd5,
      S_HALT = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      OPC_BRA  = 3'd0,
      OPC_BNE  = 3'd1,
      OPC_MOVI = 3'd2,
      OPC_LDB  = 3'd3,
      OPC_ALU  = 3'd4,
      OPC_HLT  = 3'd5,
      OPC_NOP  = 3'd6
   } op_class_t;

   localparam logic [5:0] OP_BRA  = 6'h00;
   localparam logic [5:0] OP_BNE  = 6'h01;
   localparam logic [5:0] OP_MOVI = 6'h02;
   localparam logic [5:0] OP_LDB  = 6'h03;
   localparam logic [5:0] OP_ADD  = 6'h04;
   localparam logic [5:0] OP_SUB  = 6'h05;
   localparam logic [5:0] OP_AND  = 6'h06;
   localparam logic [5:0] OP_ORR  = 6'h07;
   localparam logic [5:0] OP_XOR  = 6'h08;
   localparam logic [5:0] OP_HLT  = 6'h3F;

   localparam logic [4:0] ALU_ADD = 5'b10100;
   localparam logic [4:0] ALU_SUB = 5'b10110;
   localparam logic [4:0] ALU_AND = 5'b10111;
   localparam logic [4:0] ALU_ORR = 5'b11000;
   localparam logic [4:0] ALU_XOR = 5'b11001;

   localparam logic [2:0] RF_FUN_LOAD    = 3'b010;
   localparam logic [1:0] ARF_FUN_DEC    = 2'b00;
   localparam logic [1:0] ARF_FUN_INC    = 2'b01;
   localparam logic [1:0] ARF_FUN_LOAD   = 2'b10;
   localparam logic [1:0] ARF_FUN_CLR    = 2'b11;
   localparam logic [1:0] DR_FUN_LOAD_LO = 2'b01;

   localparam logic [1:0] ARF_SEL_PC = 2'b00;
   localparam logic [1:0] ARF_SEL_AR = 2'b10;
   localparam logic [1:0] ARF_SEL_SP = 2'b11;
   localparam logic [2:0] ARF_REG_PC = 3'b100;

   localparam logic [1:0] MUXA_ALU = 2'b00;
   localparam logic [1:0] MUXA_DR  = 2'b10;
   localparam logic [1:0] MUXA_IMM = 2'b11;
   localparam logic [1:0] MUXB_IMM = 2'b11;

   typedef struct packed {
      logic [2:0] rf_outa_sel;
      logic [2:0] rf_outb_sel;
      logic [2:0] rf_fun_sel;
      logic [3:0] rf_reg_sel;
      logic [3:0] rf_scr_sel;
      logic [4:0] alu_fun_sel;
      logic       alu_wf;
      logic [1:0] arf_outc_sel;
      logic [1:0] arf_outd_sel;
      logic [1:0] arf_fun_sel;
      logic [2:0] arf_reg_sel;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic [1:0] mux_c_sel;
      logic       mux_d_sel;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_cs;
      logic       mem_wr;
      logic       dr_e;
      logic [1:0] dr_fun_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      rf_outa_sel: 3'b000, rf_outb_sel: 3'b000, rf_fun_sel: 3'b000,
      rf_reg_sel: 4'b0000, rf_scr_sel: 4'b0000, alu_fun_sel: 5'b00000,
      alu_wf: 1'b0, arf_outc_sel: 2'b00, arf_outd_sel: 2'b00,
      arf_fun_sel: 2'b00, arf_reg_sel: 3'b000, mux_a_sel: 2'b00,
      mux_b_sel: 2'b00, mux_c_sel: 2'b00, mux_d_sel: 1'b0, ir_lh: 1'b0,
      ir_write: 1'b0, mem_cs: 1'b1, mem_wr: 1'b0, dr_e: 1'b0,
      dr_fun_sel: 2'b00
   };

   function automatic logic [4:0] alu_code(input logic [5:0] op);
      case (op)
         OP_ADD:  alu_code = ALU_ADD;
         OP_SUB:  alu_code = ALU_SUB;
         OP_AND:  alu_code = ALU_AND;
         OP_ORR:  alu_code = ALU_ORR;
         OP_XOR:  alu_code = ALU_XOR;
         default: alu_code = 5'b00000;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_decoder.sv
// instruction_decoder: splits the instruction word into fields, classifies the
// opcode and builds the one-hot register-file write select.
`default_nettype none

module instruction_decoder
   import control_unit_pkg::*;
(
   input  logic [15:0] ir,
   output logic [2:0]  op_class,
   output logic [2:0]  src1,
   output logic [2:0]  src2,
   output logic        s_flag,
   output logic [4:0]  alu_fun,
   output logic [3:0]  rf_onehot
);

   logic [5:0] op;
   logic       is_alu;
   logic [1:0] rf_idx;

   assign op     = ir[15:10];
   assign src1   = ir[5:3];
   assign src2   = ir[2:0];
   assign s_flag = ir[9];
   assign is_alu = (op >= OP_ADD) && (op <= OP_XOR);

   always_comb begin
      op_class = OPC_NOP;
      case (op)
         OP_BRA:  op_class = OPC_BRA;
         OP_BNE:  op_class = OPC_BNE;
         OP_MOVI: op_class = OPC_MOVI;
         OP_LDB:  op_class = OPC_LDB;
         OP_HLT:  op_class = OPC_HLT;
         default: op_class = is_alu ? OPC_ALU : OPC_NOP;
      endcase
   end

   assign alu_fun = alu_code(op);

   // ALU results land in dst[1:0] = IR[7:6]; MOVI/LDB target rsel = IR[9:8]
   assign rf_idx    = is_alu ? ir[7:6] : ir[9:8];
   assign rf_onehot = 4'b1000 >> rf_idx;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// control_unit: hardwired fetch/decode/execute sequencer driving every control
// input of the ALU-system datapath.
`default_nettype none

module control_unit
   import control_unit_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  Flags,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [1:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic [1:0]  MuxCSel,
   output logic        MuxDSel,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic        Mem_CS,
   output logic        Mem_WR,
   output logic        DR_E,
   output logic [1:0]  DR_FunSel
);

   state_t     state;
   state_t     state_next;
   ctrl_t      ctrl;
   logic [2:0] op_class;
   logic [2:0] src1;
   logic [2:0] src2;
   logic       s_flag;
   logic [4:0] alu_fun;
   logic [3:0] rf_onehot;
   logic       unused_flags;

   assign unused_flags = ^Flags[2:0];

   instruction_decoder u_decoder (
      .ir        (IROut),
      .op_class  (op_class),
      .src1      (src1),
      .src2      (src2),
      .s_flag    (s_flag),
      .alu_fun   (alu_fun),
      .rf_onehot (rf_onehot)
   );

   always_ff @(posedge Clock) begin
      if (Reset) state <= S_INIT;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      ctrl       = CTRL_IDLE;
      case (state)
         S_INIT: begin
            ctrl.arf_reg_sel = ARF_REG_PC;
            ctrl.arf_fun_sel = ARF_FUN_CLR;
            state_next       = S_F_LO;
         end
         S_F_LO, S_F_HI: begin
            ctrl.arf_outd_sel = ARF_SEL_PC;
            ctrl.mem_cs       = 1'b0;
            ctrl.ir_write     = 1'b1;
            ctrl.ir_lh        = (state == S_F_HI);
            ctrl.arf_reg_sel  = ARF_REG_PC;
            ctrl.arf_fun_sel  = ARF_FUN_INC;
            state_next        = (state == S_F_LO) ? S_F_HI : S_EX1;
         end
         S_EX1: begin
            state_next = S_EX2;
            case (op_class)
               OPC_BRA: ctrl.mux_b_sel = MUXB_IMM;
               OPC_BNE: begin
                  if (Flags[3]) state_next = S_F_LO;
                  else          ctrl.mux_b_sel = MUXB_IMM;
               end
               OPC_MOVI: ctrl.mux_a_sel = MUXA_IMM;
               OPC_LDB: begin
                  ctrl.arf_outd_sel = ARF_SEL_AR;
                  ctrl.mem_cs       = 1'b0;
                  ctrl.dr_e         = 1'b1;
                  ctrl.dr_fun_sel   = DR_FUN_LOAD_LO;
               end
               OPC_ALU: begin
                  ctrl.rf_outa_sel = src1;
                  ctrl.rf_outb_sel = src2;
                  ctrl.alu_fun_sel = alu_fun;
               end
               OPC_HLT: state_next = S_HALT;
               default: state_next = S_F_LO;
            endcase
         end
         S_EX2: begin
            state_next = S_F_LO;
            case (op_class)
               // BNE only reaches EX2 when taken
               OPC_BRA, OPC_BNE: begin
                  ctrl.mux_b_sel   = MUXB_IMM;
                  ctrl.arf_reg_sel = ARF_REG_PC;
                  ctrl.arf_fun_sel = ARF_FUN_LOAD;
               end
               OPC_MOVI: begin
                  ctrl.mux_a_sel  = MUXA_IMM;
                  ctrl.rf_fun_sel = RF_FUN_LOAD;
                  ctrl.rf_reg_sel = rf_onehot;
               end
               OPC_LDB: begin
                  ctrl.mux_a_sel = MUXA_DR;
                  state_next     = S_EX3;
               end
               OPC_ALU: begin
                  ctrl.rf_outa_sel = src1;
                  ctrl.rf_outb_sel = src2;
                  ctrl.alu_fun_sel = alu_fun;
                  ctrl.alu_wf      = s_flag;
                  ctrl.mux_a_sel   = MUXA_ALU;
                  state_next       = S_EX3;
               end
               default: state_next = S_F_LO;
            endcase
         end
         S_EX3: begin
            state_next      = S_F_LO;
            ctrl.mux_a_sel  = (op_class == OPC_LDB) ? MUXA_DR : MUXA_ALU;
            ctrl.rf_fun_sel = RF_FUN_LOAD;
            ctrl.rf_reg_sel = rf_onehot;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_INIT;
      endcase
      if (Reset) ctrl = CTRL_IDLE;
   end

   assign RF_OutASel  = ctrl.rf_outa_sel;
   assign RF_OutBSel  = ctrl.rf_outb_sel;
   assign RF_FunSel   = ctrl.rf_fun_sel;
   assign RF_RegSel   = ctrl.rf_reg_sel;
   assign RF_ScrSel   = ctrl.rf_scr_sel;
   assign ALU_FunSel  = ctrl.alu_fun_sel;
   assign ALU_WF      = ctrl.alu_wf;
   assign ARF_OutCSel = ctrl.arf_outc_sel;
   assign ARF_OutDSel = ctrl.arf_outd_sel;
   assign ARF_FunSel  = ctrl.arf_fun_sel;
   assign ARF_RegSel  = ctrl.arf_reg_sel;
   assign MuxASel     = ctrl.mux_a_sel;
   assign MuxBSel     = ctrl.mux_b_sel;
   assign MuxCSel     = ctrl.mux_c_sel;
   assign MuxDSel     = ctrl.mux_d_sel;
   assign IR_LH       = ctrl.ir_lh;
   assign IR_Write    = ctrl.ir_write;
   assign Mem_CS      = ctrl.mem_cs;
   assign Mem_WR      = ctrl.mem_wr;
   assign DR_E        = ctrl.dr_e;
   assign DR_FunSel   = ctrl.dr_fun_sel;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: cycle-exact scoreboard check of every control output over
// reset, fetch, each instruction class, halt and mid-instruction reset.
`default_nettype none

module tb_control_unit;

   typedef struct packed {
      logic [2:0] outa;
      logic [2:0] outb;
      logic [2:0] rf_fun;
      logic [3:0] rf_reg;
      logic [3:0] rf_scr;
      logic [4:0] alu_fun;
      logic       alu_wf;
      logic [1:0] outc;
      logic [1:0] outd;
      logic [1:0] arf_fun;
      logic [2:0] arf_reg;
      logic [1:0] mux_a;
      logic [1:0] mux_b;
      logic [1:0] mux_c;
      logic       mux_d;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_cs;
      logic       mem_wr;
      logic       dr_e;
      logic [1:0] dr_fun;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ir_out = 16'h0000;
   logic [3:0]  flags = 4'b0000;

   logic [2:0] rf_outa_sel, rf_outb_sel, rf_fun_sel;
   logic [3:0] rf_reg_sel, rf_scr_sel;
   logic [4:0] alu_fun_sel;
   logic       alu_wf;
   logic [1:0] arf_outc_sel, arf_outd_sel, arf_fun_sel;
   logic [2:0] arf_reg_sel;
   logic [1:0] mux_a_sel, mux_b_sel, mux_c_sel;
   logic       mux_d_sel, ir_lh, ir_write, mem_cs, mem_wr, dr_e;
   logic [1:0] dr_fun_sel;
   logic [45:0] dut_vec;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_run = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   control_unit dut (
      .Clock       (clk),
      .Reset       (rst),
      .IROut       (ir_out),
      .Flags       (flags),
      .RF_OutASel  (rf_outa_sel),
      .RF_OutBSel  (rf_outb_sel),
      .RF_FunSel   (rf_fun_sel),
      .RF_RegSel   (rf_reg_sel),
      .RF_ScrSel   (rf_scr_sel),
      .ALU_FunSel  (alu_fun_sel),
      .ALU_WF      (alu_wf),
      .ARF_OutCSel (arf_outc_sel),
      .ARF_OutDSel (arf_outd_sel),
      .ARF_FunSel  (arf_fun_sel),
      .ARF_RegSel  (arf_reg_sel),
      .MuxASel     (mux_a_sel),
      .MuxBSel     (mux_b_sel),
      .MuxCSel     (mux_c_sel),
      .MuxDSel     (mux_d_sel),
      .IR_LH       (ir_lh),
      .IR_Write    (ir_write),
      .Mem_CS      (mem_cs),
      .Mem_WR      (mem_wr),
      .DR_E        (dr_e),
      .DR_FunSel   (dr_fun_sel)
   );

   assign dut_vec = {rf_outa_sel, rf_outb_sel, rf_fun_sel, rf_reg_sel, rf_scr_sel,
                     alu_fun_sel, alu_wf, arf_outc_sel, arf_outd_sel, arf_fun_sel,
                     arf_reg_sel, mux_a_sel, mux_b_sel, mux_c_sel, mux_d_sel,
                     ir_lh, ir_write, mem_cs, mem_wr, dr_e, dr_fun_sel};

   function automatic exp_t e_idle();
      exp_t e;
      e = '0;
      e.mem_cs = 1'b1;
      return e;
   endfunction

   function automatic exp_t e_init();
      exp_t e;
      e = e_idle();
      e.arf_reg = 3'b100;
      e.arf_fun = 2'b11;
      return e;
   endfunction

   function automatic exp_t e_fetch(input logic hi);
      exp_t e;
      e = e_idle();
      e.outd     = 2'b00;
      e.mem_cs   = 1'b0;
      e.ir_write = 1'b1;
      e.ir_lh    = hi;
      e.arf_reg  = 3'b100;
      e.arf_fun  = 2'b01;
      return e;
   endfunction

   task automatic expect_cycle(input string nm, input exp_t v);
      name_q.push_back(nm);
      exp_q.push_back(v);
   endtask

   task automatic expect_fetch(input string tag);
      expect_cycle({tag, "_f_lo"}, e_fetch(1'b0));
      expect_cycle({tag, "_f_hi"}, e_fetch(1'b1));
   endtask

   task automatic test_reset();
      exp_t want;
      string nm;
      rst = 1'b1;
      expect_cycle("reset_c0", e_idle());
      expect_cycle("reset_c1", e_idle());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      expect_cycle("reset_init", e_init());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_movi();
      exp_t want, e;
      string nm;
      ir_out = 16'h0A5A;
      expect_fetch("movi");
      e = e_idle(); e.mux_a = 2'b11;
      expect_cycle("movi_ex1", e);
      e.rf_fun = 3'b010; e.rf_reg = 4'b0010;
      expect_cycle("movi_ex2", e);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_alu_op(input string tag, input logic [15:0] ir,
                              input logic [2:0] outa, input logic [2:0] outb,
                              input logic [4:0] fun, input logic wf,
                              input logic [3:0] rf_reg);
      exp_t want, e;
      string nm;
      ir_out = ir;
      expect_fetch(tag);
      e = e_idle(); e.outa = outa; e.outb = outb; e.alu_fun = fun; e.mux_d = 1'b0;
      expect_cycle({tag, "_ex1"}, e);
      e.alu_wf = wf; e.mux_a = 2'b00;
      expect_cycle({tag, "_ex2"}, e);
      e = e_idle(); e.mux_a = 2'b00; e.rf_fun = 3'b010; e.rf_reg = rf_reg;
      expect_cycle({tag, "_ex3"}, e);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ldb();
      exp_t want, e;
      string nm;
      ir_out = 16'h0D33;
      expect_fetch("ldb");
      e = e_idle(); e.outd = 2'b10; e.mem_cs = 1'b0; e.dr_e = 1'b1; e.dr_fun = 2'b01;
      expect_cycle("ldb_ex1", e);
      e = e_idle(); e.mux_a = 2'b10;
      expect_cycle("ldb_ex2", e);
      e.rf_fun = 3'b010; e.rf_reg = 4'b0100;
      expect_cycle("ldb_ex3", e);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      exp_t want, e;
      string nm;
      for (int ph = 0; ph < 3; ph++) begin
         // 0: BNE with Z set, 1: BNE with Z clear, 2: BRA ignores Z
         ir_out = (ph == 2) ? 16'h00FF : 16'h0440;
         flags  = (ph == 1) ? 4'b0000 : 4'b1000;
         expect_fetch("branch");
         if (ph == 0) begin
            expect_cycle("bne_nt_ex1", e_idle());
         end else begin
            e = e_idle(); e.mux_b = 2'b11;
            expect_cycle("branch_taken_ex1", e);
            e.arf_reg = 3'b100; e.arf_fun = 2'b10;
            expect_cycle("branch_taken_ex2", e);
         end
         while (exp_q.size() != 0) begin
            @(negedge clk);
            want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
            if (dut_vec !== want) begin
               n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
            end
            @(posedge clk); #1;
         end
      end
      flags = 4'b0000;
   endtask

   task automatic test_nop();
      exp_t want;
      string nm;
      ir_out = 16'h4000;
      expect_fetch("nop");
      expect_cycle("nop_ex1", e_idle());
      expect_fetch("nop_next");
      ir_out = 16'h4000;
      expect_cycle("nop_next_ex1", e_idle());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      exp_t want, e;
      string nm;
      ir_out = 16'h120B;
      expect_fetch("rstmid");
      e = e_idle(); e.outa = 3'b001; e.outb = 3'b011; e.alu_fun = 5'b10100;
      expect_cycle("rstmid_ex1", e);
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      expect_cycle("rstmid_ex2_idle", e_idle());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      expect_cycle("rstmid_init", e_init());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      exp_t want;
      string nm;
      ir_out = 16'hFC00;
      expect_fetch("hlt");
      expect_cycle("hlt_ex1", e_idle());
      for (int i = 0; i < 10; i++) expect_cycle("halt_hold", e_idle());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      expect_cycle("halt_reset", e_idle());
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
      rst = 1'b0;
      expect_cycle("halt_exit_init", e_init());
      expect_cycle("halt_exit_f_lo", e_fetch(1'b0));
      while (exp_q.size() != 0) begin
         @(negedge clk);
         want = exp_q.pop_front(); nm = name_q.pop_front(); n_run++;
         if (dut_vec !== want) begin
            n_fail++; $display("FAIL %s: actual %h required %h", nm, dut_vec, want);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d run %0d failed", n_run, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_movi();
      test_alu_op("add", 16'h120B, 3'b001, 3'b011, 5'b10100, 1'b1, 4'b1000);
      test_alu_op("xor", 16'h20D1, 3'b010, 3'b001, 5'b11001, 1'b0, 4'b0001);
      test_ldb();
      test_branch();
      test_nop();
      test_reset_mid();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
